// File: rtl/hex_calc_core.sv
// rtl/hex_calc_core.sv - parametrised unsigned hex calculator core with multi-cycle multiply/divide
module hex_calc_core #(
    parameter int NDIG = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              key_valid_i,
    input  logic [3:0]        key_code_i,
    output logic [4*NDIG-1:0] digits_o,
    output logic              busy_o,
    output logic              error_o,
    output logic              op_pending_o
);
    localparam int W  = 4 * NDIG;
    localparam int CW = $clog2(NDIG + 1);
    localparam int SW = $clog2(W);
    localparam logic [CW-1:0] CMAX = CW'(NDIG);
    localparam logic [SW-1:0] LAST = SW'(W - 1);
    localparam logic [1:0] S_ENTRY = 2'd0, S_EXEC = 2'd1, S_ERROR = 2'd2;
    localparam logic [3:0] K_ADD = 4'hA, K_SUB = 4'hB, K_MUL = 4'hC, K_DIV = 4'hD,
                           K_EQ = 4'hE, K_CLR = 4'hF;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  digits_q, digits_d, acc_q, acc_d, opnd_q, opnd_d;
    logic [W-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] step_q, step_d;
    logic [3:0]    op_q, op_d, nop_q, nop_d;
    logic          fresh_q, fresh_d, bdig_q, bdig_d;

    logic [W:0]    add_full, sub_full, mul_sum, div_rs;
    logic [W-1:0]  div_sub, nhi, nlo, ent_digits, fin_res;
    logic [CW-1:0] ent_cnt;
    logic          div_ge, do_eval, fin_ok, fin_err;
    logic [3:0]    eval_nop, fin_nop;

    assign add_full   = {1'b0, acc_q} + {1'b0, digits_q};
    assign sub_full   = {1'b0, acc_q} - {1'b0, digits_q};
    assign mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_rs     = {hi_q, lo_q[W-1]};
    assign div_ge     = div_rs >= {1'b0, opnd_q};
    assign div_sub    = div_rs[W-1:0] - opnd_q;
    assign ent_digits = fresh_q ? '0 : digits_q;
    assign ent_cnt    = fresh_q ? '0 : cnt_q;

    // One iteration: add-then-shift-right multiply, or restoring divide with quotient in lo
    always_comb begin
        nhi = hi_q;
        nlo = lo_q;
        if (op_q == K_MUL) begin
            nhi = mul_sum[W:1];
            nlo = {mul_sum[0], lo_q[W-1:1]};
        end else if (div_ge) begin
            nhi = div_sub;
            nlo = {lo_q[W-2:0], 1'b1};
        end else begin
            nhi = div_rs[W-1:0];
            nlo = {lo_q[W-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;  digits_d = digits_q; acc_d = acc_q;   opnd_d = opnd_q;
        hi_d    = hi_q;     lo_d     = lo_q;     cnt_d = cnt_q;   step_d = step_q;
        op_d    = op_q;     nop_d    = nop_q;    fresh_d = fresh_q; bdig_d = bdig_q;
        do_eval = 1'b0;     eval_nop = '0;       fin_ok = 1'b0;   fin_err = 1'b0;
        fin_res = '0;       fin_nop  = '0;
        case (state_q)
            S_ENTRY, S_ERROR: begin
                if (key_valid_i && key_code_i == K_CLR) begin
                    state_d = S_ENTRY; digits_d = '0; acc_d = '0; cnt_d = '0;
                    op_d = '0; fresh_d = 1'b0; bdig_d = 1'b0;
                end else if (key_valid_i && state_q == S_ENTRY) begin
                    if (key_code_i <= 4'd9) begin
                        fresh_d = 1'b0;
                        bdig_d  = 1'b1;
                        digits_d = ent_digits;
                        cnt_d    = ent_cnt;
                        if (!(ent_cnt == '0 && key_code_i == 4'd0) && ent_cnt < CMAX) begin
                            digits_d = {ent_digits[W-5:0], key_code_i};
                            cnt_d    = ent_cnt + CW'(1);
                        end
                    end else if (key_code_i <= K_DIV) begin
                        if (op_q == '0) begin
                            acc_d = digits_q; op_d = key_code_i; cnt_d = '0;
                            fresh_d = 1'b1; bdig_d = 1'b0;
                        end else if (!bdig_q) begin
                            op_d = key_code_i;
                        end else begin
                            do_eval = 1'b1; eval_nop = key_code_i;
                        end
                    end else if (op_q != '0) begin
                        do_eval = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                hi_d   = nhi;
                lo_d   = nlo;
                step_d = step_q + SW'(1);
                if (step_q == LAST) begin
                    fin_nop = nop_q;
                    if (op_q == K_MUL && nhi != '0) begin
                        fin_err = 1'b1;
                    end else begin
                        fin_ok = 1'b1; fin_res = nlo;
                    end
                end
            end
            default: state_d = S_ENTRY;
        endcase

        if (do_eval) begin
            fin_nop = eval_nop;
            case (op_q)
                K_ADD: begin
                    fin_err = add_full[W]; fin_ok = !add_full[W]; fin_res = add_full[W-1:0];
                end
                K_SUB: begin
                    fin_err = sub_full[W]; fin_ok = !sub_full[W]; fin_res = sub_full[W-1:0];
                end
                K_MUL: begin
                    state_d = S_EXEC; opnd_d = acc_q; hi_d = '0; lo_d = digits_q;
                    step_d = '0; nop_d = eval_nop;
                end
                default: begin
                    if (digits_q == '0) begin
                        fin_err = 1'b1;
                    end else begin
                        state_d = S_EXEC; opnd_d = digits_q; hi_d = '0; lo_d = acc_q;
                        step_d = '0; nop_d = eval_nop;
                    end
                end
            endcase
        end

        if (fin_err) begin
            state_d = S_ERROR; op_d = '0; cnt_d = '0; fresh_d = 1'b0; bdig_d = 1'b0;
        end else if (fin_ok) begin
            state_d = S_ENTRY; digits_d = fin_res; acc_d = fin_res; op_d = fin_nop;
            cnt_d = '0; fresh_d = 1'b1; bdig_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_ENTRY; digits_q <= '0; acc_q <= '0; opnd_q <= '0;
            hi_q    <= '0;      lo_q     <= '0; cnt_q <= '0; step_q <= '0;
            op_q    <= '0;      nop_q    <= '0; fresh_q <= 1'b0; bdig_q <= 1'b0;
        end else begin
            state_q <= state_d; digits_q <= digits_d; acc_q <= acc_d; opnd_q <= opnd_d;
            hi_q    <= hi_d;    lo_q     <= lo_d;     cnt_q <= cnt_d; step_q <= step_d;
            op_q    <= op_d;    nop_q    <= nop_d;    fresh_q <= fresh_d; bdig_q <= bdig_d;
        end
    end

    assign error_o      = (state_q == S_ERROR);
    assign busy_o       = (state_q == S_EXEC);
    assign digits_o     = error_o ? '1 : digits_q;
    assign op_pending_o = (op_q != '0) && !error_o;
endmodule

// File: tb/tb_hex_calc_core.sv
// tb/tb_hex_calc_core.sv - self-checking bench for hex_calc_core against an arithmetic reference model
module tb_hex_calc_core;
    localparam int W = 16;
    localparam longint unsigned MAXV = 64'hFFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          kv, busy, err, opp;
    logic [3:0]    kc;
    logic [W-1:0]  dig;
    logic          kv6, busy6, err6, opp6;
    logic [3:0]    kc6;
    logic [23:0]   dig6;

    always #5 clk = ~clk;

    hex_calc_core #(.NDIG(4)) dut (
        .clk_i(clk), .rst_i(rst), .key_valid_i(kv), .key_code_i(kc),
        .digits_o(dig), .busy_o(busy), .error_o(err), .op_pending_o(opp)
    );
    hex_calc_core #(.NDIG(6)) dut6 (
        .clk_i(clk), .rst_i(rst), .key_valid_i(kv6), .key_code_i(kc6),
        .digits_o(dig6), .busy_o(busy6), .error_o(err6), .op_pending_o(opp6)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int busy_seen;

    longint unsigned m_disp, m_acc;
    int m_op, m_cnt, m_busy;
    bit m_clear_next, m_b, m_err;

    function automatic void model_eval(input int nop);
        longint unsigned a = m_acc;
        longint unsigned b = m_disp;
        longint unsigned r = 0;
        bit bad = 0;
        case (m_op)
            10: begin r = a + b; bad = (r > MAXV); end
            11: begin bad = (a < b); r = a - b; end
            12: begin r = a * b; bad = (r > MAXV); m_busy = W; end
            default: begin
                if (b == 0) bad = 1;
                else begin r = a / b; m_busy = W; end
            end
        endcase
        if (bad) begin
            m_err = 1; m_op = 0;
        end else begin
            m_disp = r; m_acc = r; m_op = nop; m_clear_next = 1; m_b = 0; m_cnt = 0;
        end
    endfunction

    function automatic void model_key(input int k);
        m_busy = 0;
        if (k == 15) begin
            m_disp = 0; m_acc = 0; m_op = 0; m_cnt = 0; m_clear_next = 0; m_b = 0; m_err = 0;
        end else if (m_err) begin
        end else if (k <= 9) begin
            if (m_clear_next) begin m_disp = 0; m_cnt = 0; m_clear_next = 0; end
            m_b = 1;
            if (!(m_cnt == 0 && k == 0) && m_cnt < W / 4) begin
                m_disp = m_disp * 16 + longint'(k); m_cnt++;
            end
        end else if (k <= 13) begin
            if (m_op == 0) begin
                m_acc = m_disp; m_op = k; m_cnt = 0; m_clear_next = 1; m_b = 0;
            end else if (!m_b) m_op = k;
            else model_eval(k);
        end else if (m_op != 0) begin
            model_eval(0);
        end
    endfunction

    function automatic logic [W-1:0] exp_dig();
        return m_err ? W'(MAXV) : W'(m_disp);
    endfunction

    task automatic press(input logic [3:0] k, input bit wait_done);
        @(negedge clk); kv = 1'b1; kc = k;
        @(negedge clk); kv = 1'b0;
        model_key(int'(k));
        busy_seen = 0;
        if (wait_done)
            while (busy === 1'b1 && busy_seen < 4 * W) begin busy_seen++; @(negedge clk); end
    endtask

    task automatic keys(input logic [63:0] s, input int n);
        for (int i = n - 1; i >= 0; i--) press(s[4*i +: 4], 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1; kv = 1'b0; kc = '0; kv6 = 1'b0; kc6 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_key(15);
        n_checks++; if (dig !== '0) begin n_fail++; $display("FAIL reset_digits got %h want 0000", dig); end
        n_checks++; if ({busy, err, opp} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {busy, err, opp}); end
        n_checks++; if ({dig6, busy6, err6, opp6} !== '0) begin n_fail++; $display("FAIL reset_ndig6 got %h/%b want 0", dig6, {busy6, err6, opp6}); end
    endtask

    task automatic test_add();
        keys(64'hF12A34E, 7);
        n_checks++; if (dig !== 16'h0046) begin n_fail++; $display("FAIL add_basic got %h want 0046", dig); end
        n_checks++; if ({err, opp} !== 2'b00) begin n_fail++; $display("FAIL add_flags got %b want 00", {err, opp}); end
        keys(64'hA, 1);
        n_checks++; if (opp !== 1'b1) begin n_fail++; $display("FAIL add_op_pending got %b want 1", opp); end
        keys(64'h1E, 2);
        n_checks++; if (dig !== 16'h0047) begin n_fail++; $display("FAIL add_reuse got %h want 0047", dig); end
    endtask

    task automatic test_error_add();
        keys(64'hF9999A9999E, 11);
        n_checks++; if ({err, opp, dig} !== {2'b10, 16'hFFFF}) begin n_fail++; $display("FAIL add_carry got %b %h want 10 ffff", {err, opp}, dig); end
        keys(64'h5, 1);
        n_checks++; if ({err, dig} !== {1'b1, 16'hFFFF}) begin n_fail++; $display("FAIL error_hold got %b %h want 1 ffff", err, dig); end
        keys(64'hF, 1);
        n_checks++; if ({err, dig} !== {1'b0, 16'h0000}) begin n_fail++; $display("FAIL error_clear got %b %h want 0 0000", err, dig); end
    endtask

    task automatic test_sub();
        keys(64'h3B5E, 4);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL sub_negative err got %b want 1", err); end
        keys(64'hF9B9E, 5);
        n_checks++; if ({err, dig} !== {1'b0, 16'h0000}) begin n_fail++; $display("FAIL sub_zero got %b %h want 0 0000", err, dig); end
    endtask

    task automatic test_mul();
        keys(64'hF99C101E, 8);
        n_checks++; if (busy_seen !== W) begin n_fail++; $display("FAIL mul_busy got %0d want %0d", busy_seen, W); end
        n_checks++; if (dig !== 16'h9999) begin n_fail++; $display("FAIL mul_result got %h want 9999", dig); end
        keys(64'hF1234C10E, 9);
        n_checks++; if ({err, dig} !== {1'b1, 16'hFFFF}) begin n_fail++; $display("FAIL mul_overflow got %b %h want 1 ffff", err, dig); end
    endtask

    task automatic test_div();
        keys(64'hF64D7E, 6);
        n_checks++; if (busy_seen !== W) begin n_fail++; $display("FAIL div_busy got %0d want %0d", busy_seen, W); end
        n_checks++; if (dig !== 16'h000E) begin n_fail++; $display("FAIL div_result got %h want 000e", dig); end
        keys(64'hF64D0E, 6);
        n_checks++; if ({err, busy_seen} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL div_zero got err=%b busy=%0d want err=1 busy=0", err, busy_seen); end
    endtask

    task automatic test_chain();
        keys(64'hF2A3C, 5);
        n_checks++; if ({opp, dig} !== {1'b1, 16'h0005}) begin n_fail++; $display("FAIL chain_mid got %b %h want 1 0005", opp, dig); end
        keys(64'h4E, 2);
        n_checks++; if ({opp, dig} !== {1'b0, 16'h0014}) begin n_fail++; $display("FAIL chain_end got %b %h want 0 0014", opp, dig); end
    endtask

    task automatic test_entry_limits();
        keys(64'hF123456, 7);
        n_checks++; if (dig !== 16'h1234) begin n_fail++; $display("FAIL digit_limit got %h want 1234", dig); end
        keys(64'hF007, 4);
        n_checks++; if (dig !== 16'h0007) begin n_fail++; $display("FAIL leading_zero got %h want 0007", dig); end
    endtask

    task automatic test_busy_drop();
        int bc;
        keys(64'hF64D7, 5);
        press(4'hE, 1'b0);
        bc = 0;
        while (busy === 1'b1 && bc < 4 * W) begin
            bc++;
            kv = (bc == 3 || bc == W);
            kc = 4'hF;
            @(negedge clk);
        end
        kv = 1'b0;
        n_checks++; if (bc !== W) begin n_fail++; $display("FAIL drop_busy got %0d want %0d", bc, W); end
        n_checks++; if ({err, dig} !== {1'b0, 16'h000E}) begin n_fail++; $display("FAIL drop_result got %b %h want 0 000e", err, dig); end
    endtask

    task automatic test_rst_mid_div();
        keys(64'hF64D7, 5);
        press(4'hE, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({dig, busy, err, opp} !== '0) begin n_fail++; $display("FAIL rst_abort got %h %b want 0", dig, {busy, err, opp}); end
        @(negedge clk); rst = 1'b0;
        repeat (2 * W) @(negedge clk);
        n_checks++; if ({dig, busy, err, opp} !== '0) begin n_fail++; $display("FAIL rst_no_write got %h %b want 0", dig, {busy, err, opp}); end
        model_key(15);
    endtask

    task automatic test_ndig6();
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk); kv6 = 1'b1; kc6 = 4'(i);
            @(negedge clk); kv6 = 1'b0;
        end
        n_checks++; if (dig6 !== 24'h123456) begin n_fail++; $display("FAIL ndig6_entry got %h want 123456", dig6); end
    endtask

    task automatic test_random();
        int r;
        logic [3:0] k;
        keys(64'hF, 1);
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60)      k = 4'($urandom_range(0, 9));
            else if (r < 85) k = 4'($urandom_range(10, 13));
            else if (r < 96) k = 4'hE;
            else             k = 4'hF;
            press(k, 1'b1);
            n_checks++; if (dig !== exp_dig()) begin n_fail++; $display("FAIL rand_digits key=%h got %h want %h", k, dig, exp_dig()); end
            n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL rand_error key=%h got %b want %b", k, err, m_err); end
            n_checks++; if (opp !== (m_op != 0 && !m_err)) begin n_fail++; $display("FAIL rand_op_pending key=%h got %b", k, opp); end
            n_checks++; if (busy_seen !== m_busy) begin n_fail++; $display("FAIL rand_busy key=%h got %0d want %0d", k, busy_seen, m_busy); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_error_add();
        test_sub();
        test_mul();
        test_div();
        test_chain();
        test_entry_limits();
        test_busy_drop();
        test_rst_mid_div();
        test_ndig6();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
